// File: rtl/icache_refill_unit.sv
// icache_refill_unit
// Refill engine between the instruction RAM and icache_controller. On a miss it
// latches the 64-byte aligned line base and fetches the line one word at a time
// over a req/gnt/rvalid handshake, handing each word to the controller with a
// one-cycle word_ready strobe.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   cache_miss           miss indication from the controller
//   ram_address          line base from the controller (low 6 bits zero)
//   mem_req/mem_addr     RAM read request and byte address of the word
//   mem_gnt              RAM accepted the request
//   mem_rvalid/rdata     RAM read data return
//   mem_word/word_ready  registered word to the controller and its strobe
//   refill_busy          engine not idle
//   refill_error         sticky watchdog error
//
// Build option: define ICACHE_REFILL_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES). Without it WAIT waits forever and refill_error is 0.
//
// state  | meaning
// IDLE   | no refill; waiting for cache_miss
// REQ    | mem_req asserted for word idx, waiting for mem_gnt
// WAIT   | request granted, waiting for mem_rvalid
// DONE   | line delivered, waiting for cache_miss to drop

module icache_refill_unit #(
   parameter int PC_SIZE        = 32,
   parameter int MEM_WORD       = 32,
   parameter int BLOCK_WORDS    = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                cache_miss,
   input  logic [PC_SIZE-1:0]  ram_address,
   output logic                mem_req,
   output logic [PC_SIZE-1:0]  mem_addr,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [MEM_WORD-1:0] mem_rdata,
   output logic [MEM_WORD-1:0] mem_word,
   output logic                word_ready,
   output logic                refill_busy,
   output logic                refill_error
);

   localparam int IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam int BYTES = MEM_WORD / 8;

   if (TIMEOUT_CYCLES < 1 || BLOCK_WORDS < 2) begin : g_param_check
      $error("icache_refill_unit: TIMEOUT_CYCLES and BLOCK_WORDS out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PC_SIZE-1:0]  base_q, base_d;
   logic [MEM_WORD-1:0] word_q, word_d;
   logic                ready_q, ready_d;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   // Down-counter of WAIT cycles left before the watchdog fires.
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                err_q, err_d;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         word_q  <= '0;
         ready_q <= 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
         tmo_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         word_q  <= word_d;
         ready_q <= ready_d;
`ifdef ICACHE_REFILL_TIMEOUT_EN
         tmo_q   <= tmo_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      base_d   = base_q;
      word_d   = word_q;
      ready_d  = 1'b0;
      mem_req  = 1'b0;
      mem_addr = '0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
      tmo_d    = tmo_q;
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cache_miss) begin
               base_d  = ram_address & {{(PC_SIZE-6){1'b1}}, 6'h00};
               idx_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            mem_req  = 1'b1;
            // The line is 64-byte aligned, so base + offset never carries out.
            mem_addr = base_q + (PC_SIZE'(idx_q) * PC_SIZE'(BYTES));
            if (mem_gnt) begin
               state_d = S_WAIT;
`ifdef ICACHE_REFILL_TIMEOUT_EN
               tmo_d   = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               word_d  = mem_rdata;
               ready_d = 1'b1;
               if (idx_q == IDX_W'(BLOCK_WORDS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_REQ;
               end
            end
`ifdef ICACHE_REFILL_TIMEOUT_EN
            else if (tmo_q == '0) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
`endif
         end
         S_DONE: begin
            // Hold until the controller has written the line and stops missing.
            if (!cache_miss) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_word    = word_q;
   assign word_ready  = ready_q;
   assign refill_busy = (state_q != S_IDLE);
`ifdef ICACHE_REFILL_TIMEOUT_EN
   assign refill_error = err_q;
`else
   assign refill_error = 1'b0;
`endif

endmodule

// File: tb/tb_icache_refill_unit.sv
module tb_icache_refill_unit;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        cache_miss = 1'b0;
   logic [31:0] ram_address = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] mem_word;
   logic        word_ready;
   logic        refill_busy;
   logic        refill_error;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   // RAM model knobs
   int gnt_delay = 0, rv_delay = 0, rv_limit = 16, spurious = 0;
   int delivered = 0, pending = 0, rv_cnt = 0, g_cnt = 0;
   logic [31:0] req_addr = '0;

   // Logs from the monitor
   logic [31:0] wq_data[$];
   int          wq_cyc[$];
   logic [31:0] aq[$];
   int          dbl_wr = 0, unstable = 0;
   logic        prev_wr = 0, prev_req = 0, prev_gnt = 0;
   logic [31:0] prev_addr = '0;

   icache_refill_unit dut (
      .clk(clk), .nrst(nrst), .cache_miss(cache_miss), .ram_address(ram_address),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_word(mem_word),
      .word_ready(word_ready), .refill_busy(refill_busy), .refill_error(refill_error)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return 32'hA500_0000 | {8'h00, a[23:0]};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // RAM responder: grant after gnt_delay ungranted cycles, data rv_delay
   // cycles after the cycle following the grant; junk rvalid while ungranted
   // when spurious is set.
   initial forever begin
      logic granted;
      @(posedge clk);
      #1;
      if (!nrst) begin
         mem_gnt = 0; mem_rvalid = 0; pending = 0; g_cnt = 0;
      end else begin
         granted = mem_gnt;
         mem_gnt = 0;
         mem_rvalid = 0;
         if (granted) begin pending = 1; rv_cnt = 0; end
         if (pending != 0) begin
            if (rv_cnt == rv_delay && delivered < rv_limit) begin
               mem_rvalid = 1; mem_rdata = data_of(req_addr); pending = 0; delivered++;
            end else if (rv_cnt < rv_delay) begin
               rv_cnt++;
            end
         end else if (mem_req) begin
            if (g_cnt == gnt_delay) begin
               mem_gnt = 1; g_cnt = 0; req_addr = mem_addr;
            end else begin
               g_cnt++;
               if (spurious != 0) begin mem_rvalid = 1; mem_rdata = 32'hBAD0_0000 | g_cnt; end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (nrst) begin
         if (word_ready) begin
            wq_data.push_back(mem_word); wq_cyc.push_back(cyc);
            if (prev_wr) dbl_wr++;
         end
         if (mem_req && mem_gnt) aq.push_back(mem_addr);
         if (prev_req && !prev_gnt && (!mem_req || mem_addr !== prev_addr)) unstable++;
      end
      prev_wr = word_ready; prev_req = mem_req; prev_gnt = mem_gnt; prev_addr = mem_addr;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   task automatic config_ram(input int gd, input int rd, input int lim, input int sp);
      gnt_delay = gd; rv_delay = rd; rv_limit = lim; spurious = sp;
      delivered = 0; pending = 0; g_cnt = 0; rv_cnt = 0;
      wq_data.delete(); wq_cyc.delete(); aq.delete();
      dbl_wr = 0; unstable = 0;
   endtask

   task automatic start_miss(input logic [31:0] a, output int n);
      @(posedge clk); #2;
      ram_address = a; cache_miss = 1'b1; n = cyc;
   endtask

   task automatic end_miss();
      @(posedge clk); #2;
      cache_miss = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_words(input int n, input int budget, input string name);
      int k = 0;
      while (wq_data.size() < n && k < budget) begin @(negedge clk); k++; end
      checks++;
      if (wq_data.size() < n)
         $display("FAIL %s_words: got %0d words, expected %0d within %0d cycles", name, wq_data.size(), n, budget);
      else passes++;
   endtask

   task automatic check_line(input string name);
      for (int k = 0; k < 16; k++) begin
         logic [31:0] ea;
         ea = 32'h1200 + 32'(k * 4);
         checks++;
         if (k >= aq.size() || aq[k] !== ea)
            $display("FAIL %s_addr[%0d]: got %h, expected %h", name, k, (k < aq.size()) ? aq[k] : 32'hx, ea);
         else passes++;
         checks++;
         if (k >= wq_data.size() || wq_data[k] !== data_of(ea))
            $display("FAIL %s_data[%0d]: got %h, expected %h", name, k, (k < wq_data.size()) ? wq_data[k] : 32'hx, data_of(ea));
         else passes++;
      end
      checks++;
      if (wq_data.size() != 16) $display("FAIL %s_count: got %0d, expected 16", name, wq_data.size());
      else passes++;
      checks++;
      if (dbl_wr != 0) $display("FAIL %s_double_ready: got %0d, expected 0", name, dbl_wr);
      else passes++;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({mem_req, word_ready, refill_busy, refill_error} !== 4'b0 || mem_addr !== 32'h0 || mem_word !== 32'h0)
         $display("FAIL reset_outputs: got req=%b rdy=%b busy=%b err=%b addr=%h word=%h, expected all 0",
                  mem_req, word_ready, refill_busy, refill_error, mem_addr, mem_word);
      else passes++;
      repeat (2) @(posedge clk);
      #2 nrst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (refill_busy !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL reset_idle: got busy=%b req=%b, expected 0 0", refill_busy, mem_req);
      else passes++;
   endtask

   task automatic test_zero_wait();
      int n;
      config_ram(0, 0, 16, 0);
      start_miss(32'h0000_1234, n);
      wait_words(16, 100, "zw");
      check_line("zw");
      checks++;
      if (wq_cyc.size() != 16 || wq_cyc[15] - n != 33)
         $display("FAIL zw_latency: got %0d, expected 33", (wq_cyc.size() == 16) ? wq_cyc[15] - n : -1);
      else passes++;
      // miss held after the last word: DONE must hold without new requests
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (refill_busy !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL done_hold[%0d]: got busy=%b req=%b, expected 1 0", k, refill_busy, mem_req);
         else passes++;
      end
      @(posedge clk); #2 cache_miss = 1'b0;
      @(negedge clk);
      checks++;
      if (refill_busy !== 1'b1) $display("FAIL done_exit_cycle: got busy=%b, expected 1", refill_busy);
      else passes++;
      @(negedge clk);
      checks++;
      if (refill_busy !== 1'b0 || aq.size() != 16)
         $display("FAIL done_idle: got busy=%b reqs=%0d, expected 0 16", refill_busy, aq.size());
      else passes++;
   endtask

   task automatic test_addr_change();
      int n;
      config_ram(0, 0, 16, 0);
      start_miss(32'h0000_1234, n);
      wait_words(5, 50, "ac_part");
      ram_address = 32'h0000_2000;
      wait_words(16, 100, "ac");
      check_line("ac");
      end_miss();
   endtask

   task automatic test_delayed();
      int n;
      config_ram(3, 2, 16, 1);
      start_miss(32'h0000_1234, n);
      wait_words(16, 400, "dl");
      check_line("dl");
      checks++;
      if (unstable != 0) $display("FAIL dl_req_stable: got %0d unstable cycles, expected 0", unstable);
      else passes++;
      end_miss();
   endtask

   task automatic test_reset_mid_wait();
      int n;
      config_ram(0, 0, 5, 0);
      start_miss(32'h0000_1234, n);
      wait_words(5, 50, "rw");
      repeat (3) @(negedge clk);
      checks++;
      if (refill_busy !== 1'b1 || mem_req !== 1'b0 || mem_word !== data_of(32'h1210) || aq.size() != 6)
         $display("FAIL rw_in_wait: got busy=%b req=%b word=%h reqs=%0d, expected 1 0 %h 6",
                  refill_busy, mem_req, mem_word, aq.size(), data_of(32'h1210));
      else passes++;
      nrst = 1'b0;
      cache_miss = 1'b0;
      #1;
      checks++;
      if ({mem_req, word_ready, refill_busy, refill_error} !== 4'b0 || mem_addr !== 32'h0 || mem_word !== 32'h0)
         $display("FAIL rw_async_reset: got req=%b rdy=%b busy=%b err=%b addr=%h word=%h, expected all 0",
                  mem_req, word_ready, refill_busy, refill_error, mem_addr, mem_word);
      else passes++;
      @(posedge clk); #2 nrst = 1'b1;
      config_ram(0, 0, 16, 0);
      repeat (4) @(negedge clk);
      checks++;
      if (refill_busy !== 1'b0 || mem_req !== 1'b0 || aq.size() != 0)
         $display("FAIL rw_stay_idle: got busy=%b req=%b reqs=%0d, expected 0 0 0", refill_busy, mem_req, aq.size());
      else passes++;
   endtask

   task automatic test_timeout();
      int n;
      int fall = -1;
      config_ram(0, 0, 0, 0);
      start_miss(32'h0000_1234, n);
      @(posedge clk); #2 cache_miss = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!refill_busy && fall < 0) fall = cyc;
      end
`ifdef ICACHE_REFILL_TIMEOUT_EN
      checks++;
      if (fall - n != 66 || refill_error !== 1'b1 || wq_data.size() != 0)
         $display("FAIL to_fire: got idle_at=%0d err=%b words=%0d, expected 66 1 0", fall - n, refill_error, wq_data.size());
      else passes++;
      config_ram(0, 0, 16, 0);
      start_miss(32'h0000_1234, n);
      wait_words(16, 100, "to_retry");
      check_line("to_retry");
      checks++;
      if (refill_error !== 1'b1) $display("FAIL to_sticky: got %b, expected 1", refill_error);
      else passes++;
      end_miss();
`else
      checks++;
      if (fall != -1 || refill_error !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL to_disabled: got idle_at=%0d err=%b req=%b, expected -1 0 0", fall, refill_error, mem_req);
      else passes++;
      @(negedge clk) nrst = 1'b0;
      @(posedge clk); #2 nrst = 1'b1;
      config_ram(0, 0, 16, 0);
`endif
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_addr_change();
      test_delayed();
      test_reset_mid_wait();
      test_timeout();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
